// File: rtl/debouncer_bank.sv
// NCH-channel lock-out debouncer: 2FF sync, accept-immediately, TIME_PERIOD lock-out, rise/fall pulses.
// Optional long-press pulse per channel when DEBOUNCER_LONGPRESS_EN is defined (o_long tied low otherwise).
module debouncer_bank #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned TIME_PERIOD = 75000,
  parameter logic        RESET_LEVEL = 1'b0,
  parameter int unsigned LONG_PERIOD = 1500000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [NCH-1:0] i_btn,
  output logic [NCH-1:0] o_debounced,
  output logic [NCH-1:0] o_rise,
  output logic [NCH-1:0] o_fall,
  output logic [NCH-1:0] o_long
);

  localparam int unsigned   TW     = $clog2(TIME_PERIOD + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIME_PERIOD - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

`ifdef DEBOUNCER_LONGPRESS_EN
  localparam int unsigned   LW    = $clog2(LONG_PERIOD + 1);
  localparam logic [LW-1:0] L_MAX = LW'(LONG_PERIOD);
  localparam logic [LW-1:0] L_ONE = LW'(1);
`endif

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic          r_aux;
    logic          r_btn;
    logic          deb_q;
    logic          rise_q;
    logic          fall_q;
    logic [TW-1:0] timer_q;
    logic          accept;

    // A difference is only acted on once the previous lock-out has fully expired.
    assign accept = (timer_q == '0) && (r_btn != deb_q);

    // NOTE: reset is asynchronous on assertion; the raw pad input is re-synchronised
    // anyway, so release only needs i_rst_n itself to be synchronous to i_clk upstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_aux   <= RESET_LEVEL;
        r_btn   <= RESET_LEVEL;
        deb_q   <= RESET_LEVEL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        timer_q <= '0;
      end else begin
        // NOTE: non-blocking assignments let the sync chain and the accept decision
        // all see the pre-edge values, exactly like the flops they describe.
        {r_btn, r_aux} <= {r_aux, i_btn[n]};
        rise_q         <= 1'b0;
        fall_q         <= 1'b0;
        if (timer_q != '0) begin
          timer_q <= timer_q - T_ONE;
        end else if (accept) begin
          deb_q   <= r_btn;
          timer_q <= RELOAD;
          rise_q  <= r_btn;
          fall_q  <= !r_btn;
        end
      end
    end

    assign o_debounced[n] = deb_q;
    assign o_rise[n]      = rise_q;
    assign o_fall[n]      = fall_q;

`ifdef DEBOUNCER_LONGPRESS_EN
    logic [LW-1:0] hold_q;
    logic          long_q;

    // Counting starts on the edge that raises o_rise, so o_long lands LONG_PERIOD cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if ((accept && r_btn) || !deb_q) begin
          hold_q <= '0;
        end else if (hold_q != L_MAX) begin
          hold_q <= hold_q + L_ONE;
          long_q <= (hold_q == L_MAX - L_ONE);
        end
      end
    end

    assign o_long[n] = long_q;
`else
    assign o_long[n] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Scoreboard bench for debouncer_bank (NCH=4, TIME_PERIOD=8, LONG_PERIOD=20).
// Build with or without +define+DEBOUNCER_LONGPRESS_EN; long-press expectations follow the macro.
`timescale 1ns/1ps
module tb_debouncer_bank;

  localparam int NCH = 4;
  localparam int TP  = 8;
  localparam int LP  = 20;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [NCH-1:0] i_btn;
  logic [NCH-1:0] o_debounced, o_rise, o_fall, o_long;

  debouncer_bank #(
    .NCH(NCH), .TIME_PERIOD(TP), .RESET_LEVEL(1'b0), .LONG_PERIOD(LP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn),
    .o_debounced(o_debounced), .o_rise(o_rise), .o_fall(o_fall), .o_long(o_long)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, written straight from the channel behaviour description.
  logic m_aux [NCH];
  logic m_sync[NCH];
  logic m_deb [NCH];
  logic m_rise[NCH];
  logic m_fall[NCH];
  logic m_long[NCH];
  int   m_timer[NCH];
  int   m_cnt  [NCH];

  logic [15:0] exp_q[$];

  int cyc = 0;
  int last_pulse[NCH];
  int rise_cyc[NCH];
  int long_cyc[NCH];
  int long_total = 0;
  logic [NCH-1:0] act_mask;

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_aux[n] = 1'b0; m_sync[n] = 1'b0; m_deb[n] = 1'b0;
      m_rise[n] = 1'b0; m_fall[n] = 1'b0; m_long[n] = 1'b0;
      m_timer[n] = 0; m_cnt[n] = 0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] btn);
    for (int n = 0; n < NCH; n++) begin
      logic nd, nr, nf, nl;
      int   nt, nc;
      nd = m_deb[n]; nr = 1'b0; nf = 1'b0; nt = m_timer[n];
      if (m_timer[n] != 0) nt = m_timer[n] - 1;
      else if (m_sync[n] != m_deb[n]) begin
        nd = m_sync[n]; nt = TP - 1; nr = m_sync[n]; nf = !m_sync[n];
      end
      nl = 1'b0; nc = m_cnt[n];
`ifdef DEBOUNCER_LONGPRESS_EN
      if (nr || !m_deb[n]) nc = 0;
      else if (m_cnt[n] < LP) begin
        nc = m_cnt[n] + 1;
        nl = (m_cnt[n] == LP - 1);
      end
`endif
      m_deb[n] = nd; m_rise[n] = nr; m_fall[n] = nf; m_long[n] = nl;
      m_timer[n] = nt; m_cnt[n] = nc;
      m_sync[n] = m_aux[n];
      m_aux[n]  = btn[n];
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic [15:0] v;
    for (int n = 0; n < NCH; n++) begin
      v[12+n] = m_deb[n];
      v[8+n]  = m_rise[n];
      v[4+n]  = m_fall[n];
      v[n]    = m_long[n];
    end
    return v;
  endfunction

  // One clock: drive on the falling edge, push the model's expectation, compare after the rising edge.
  task automatic tick(input logic [NCH-1:0] btn, input logic rst);
    @(negedge i_clk);
    cyc++;
    i_rst_n = rst;
    i_btn   = btn;
    if (!rst) model_reset();
    else      model_step(btn);
    exp_q.push_back(model_vec());
    if (!rst) begin
      #1;
      check("rst_async", {o_debounced, o_rise, o_fall, o_long}, 16'h0);
      for (int n = 0; n < NCH; n++) last_pulse[n] = -1;
    end
    @(posedge i_clk);
    #1;
    check("cycle", {o_debounced, o_rise, o_fall, o_long}, exp_q.pop_front());
    act_mask = act_mask | o_debounced | o_rise | o_fall;
    for (int n = 0; n < NCH; n++) begin
      if (o_rise[n] || o_fall[n]) begin
        if (last_pulse[n] >= 0)
          check("pulse_spacing", (cyc - last_pulse[n] >= TP) ? 32'd1 : 32'd0, 32'd1);
        last_pulse[n] = cyc;
      end
      if (o_rise[n]) rise_cyc[n] = cyc;
      if (o_long[n]) begin long_cyc[n] = cyc; long_total++; end
    end
  endtask

  task automatic run(input logic [NCH-1:0] btn, input int n_cyc);
    for (int i = 0; i < n_cyc; i++) tick(btn, 1'b1);
  endtask

  initial begin
    int rel;
    i_rst_n = 1'b0;
    i_btn   = 4'b0001;
    act_mask = '0;
    model_reset();
    for (int n = 0; n < NCH; n++) begin
      last_pulse[n] = -1; rise_cyc[n] = -1; long_cyc[n] = -1;
    end

    // 1: button held through reset; accepted two edges after release, other channels quiet.
    repeat (3) tick(4'b0001, 1'b0);
    rel = cyc + 1;
    act_mask = '0;
    run(4'b0001, 6);
    check("t1_rise_edge", rise_cyc[0] - rel, 2);
    check("t1_quiet", {28'd0, act_mask[3:1]}, 0);

    // 2: toggling ch0 every 2 cycles; lock-out holds the level, spacing checked in tick().
    repeat (2) tick(4'b0000, 1'b0);
    run(4'b0000, 3);
    for (int i = 0; i < 12; i++) tick(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1);
    run(4'b0000, 14);

    // 3: two channels rise together; ch1 drops 3 cycles later and is held until its lock-out ends.
    repeat (2) tick(4'b0000, 1'b0);
    run(4'b0000, 3);
    for (int i = 1; i <= 12; i++) begin
      tick((i <= 3) ? 4'b0110 : 4'b0100, 1'b1);
      if (i == 3)  check("t3_rise_vec", o_rise, 4'b0110);
      if (i == 10) check("t3_ch1_held", o_debounced, 4'b0110);
      if (i == 11) check("t3_ch1_fall", o_fall, 4'b0010);
      if (i == 11) check("t3_ch1_level", o_debounced, 4'b0100);
    end
    run(4'b0000, 12);

    // 4: reset in mid lock-out (timer=4) clears the level without o_fall; fresh rise after release.
    repeat (2) tick(4'b0001, 1'b0);
    run(4'b0001, 6);
    check("t4_pre_level", o_debounced, 4'b0001);
    tick(4'b0001, 1'b0);
    check("t4_no_fall", o_fall, 4'b0000);
    tick(4'b0001, 1'b0);
    run(4'b0001, 2);
    check("t4_before_rerise", o_debounced, 4'b0000);
    tick(4'b0001, 1'b1);
    check("t4_rerise", o_rise, 4'b0001);

    // 5/6: long press on ch2, short press, then re-press.
    repeat (2) tick(4'b0000, 1'b0);
    run(4'b0000, 3);
    long_total = 0;
    run(4'b0100, 32);
`ifdef DEBOUNCER_LONGPRESS_EN
    check("t5_long_delay", long_cyc[2] - rise_cyc[2], LP);
    check("t5_long_once", long_total, 1);
`else
    check("t6_no_long", long_total, 0);
`endif
    run(4'b0000, 12);
    long_total = 0;
    run(4'b0100, 15);
    run(4'b0000, 12);
    check("t5_short_no_long", long_total, 0);
    long_total = 0;
    run(4'b0100, 26);
`ifdef DEBOUNCER_LONGPRESS_EN
    check("t5_repress_delay", long_cyc[2] - rise_cyc[2], LP);
    check("t5_repress_once", long_total, 1);
`else
    check("t6_repress_no_long", long_total, 0);
`endif
    run(4'b0000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
